ppm16_rx_deframer: RTL and testbench

//  Consumes the 4-bit symbol stream (dout/dout_valid) and packet_detected pulse of ppm16_demod.

---
 rtl/ppm16_pkg.sv | 13 +
 rtl/ppm16_sync_fifo.sv | 47 ++++
 rtl/ppm16_rx_deframer.sv | 132 +++++++++++++
 tb/tb_ppm16_rx_deframer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppm16_pkg.sv
// Shared types and defaults for the PPM16 receive path.
package ppm16_pkg;

  localparam int PPM_SYM_BITS  = 4;
  localparam int HDR_BYTES_DEF = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

endpackage

// File: rtl/ppm16_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push into a full FIFO is
// accepted when a pop happens on the same edge.
module ppm16_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_pop, do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head entry is read straight from storage; forced to zero when empty.
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset since empty masks dout.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ppm16_rx_deframer.sv
// Packs demod nibbles into bytes, parses the primary header length and
// streams header+data bytes through a FIFO tagged with sof/eof.
module ppm16_rx_deframer
  import ppm16_pkg::*;
#(
  parameter int HDR_BYTES      = HDR_BYTES_DEF,
  parameter int LEN_BYTE_IDX   = 4,
  parameter int MAX_DATA_BYTES = 64,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    packet_detected,
  input  logic                    sym_valid,
  input  logic [PPM_SYM_BITS-1:0] sym,
  output logic [7:0]              byte_out,
  output logic                    byte_valid,
  input  logic                    byte_ready,
  output logic                    byte_sof,
  output logic                    byte_eof,
  output logic                    frame_busy,
  output logic [15:0]             data_len,
  output logic                    len_clipped,
  output logic                    overflow
);

  localparam logic [15:0] HDR_LAST = 16'(HDR_BYTES - 1);
  localparam logic [15:0] LEN_MSB  = 16'(LEN_BYTE_IDX);
  localparam logic [15:0] LEN_LSB  = 16'(LEN_BYTE_IDX + 1);
  localparam logic [15:0] MAX_LIM  = 16'(MAX_DATA_BYTES);

  state_t                  state, state_nxt;
  logic                    pd_q, rise;
  logic                    phase;
  logic [PPM_SYM_BITS-1:0] n0;
  logic [15:0]             cnt;
  logic [7:0]              len_msb;
  logic [7:0]              cur_byte;
  logic                    byte_done, hdr_last, data_last;
  logic [15:0]             data_lim, len_new;
  logic [16:0]             len_sum;
  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [9:0]              fifo_din, fifo_dout;

  assign rise      = packet_detected && !pd_q;
  assign cur_byte  = {n0, sym};
  assign byte_done = (state != IDLE) && !rise && sym_valid && phase;
  assign data_lim  = (data_len > MAX_LIM) ? MAX_LIM : data_len;
  assign hdr_last  = (state == HDR)  && (cnt == HDR_LAST);
  assign data_last = (state == DATA) && (cnt == data_lim - 16'd1);
  // Length field counts bytes minus one; saturate rather than wrap at 0xFFFF.
  assign len_sum   = {1'b0, len_msb, cur_byte} + 17'd1;
  assign len_new   = len_sum[16] ? 16'hFFFF : len_sum[15:0];

  assign fifo_push = byte_done;
  assign fifo_pop  = byte_valid && byte_ready;
  assign fifo_din  = {(state == HDR) && (cnt == 16'd0), data_last, cur_byte};

  assign {byte_sof, byte_eof, byte_out} = fifo_dout;
  assign byte_valid = !fifo_empty;
  assign frame_busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state: a new edge always restarts the header, otherwise advance on byte boundaries.
  always_comb begin
    state_nxt = state;
    if (rise) begin
      state_nxt = HDR;
    end else if (byte_done) begin
      if (hdr_last)       state_nxt = DATA;
      else if (data_last) state_nxt = IDLE;
    end
  end

  // Edge detect, nibble packing, byte counter, length latch and sticky flags.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pd_q        <= 1'b0;
      phase       <= 1'b0;
      n0          <= '0;
      cnt         <= '0;
      len_msb     <= '0;
      data_len    <= '0;
      len_clipped <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      pd_q <= packet_detected;
      if (rise) begin
        // A nibble arriving with the edge is the high nibble of header byte 0.
        phase       <= sym_valid;
        n0          <= sym;
        cnt         <= '0;
        len_clipped <= 1'b0;
        overflow    <= 1'b0;
      end else if (state != IDLE && sym_valid) begin
        if (!phase) begin
          n0    <= sym;
          phase <= 1'b1;
        end else begin
          phase <= 1'b0;
          cnt   <= (hdr_last || data_last) ? 16'd0 : cnt + 16'd1;
          if (state == HDR && cnt == LEN_MSB) len_msb <= cur_byte;
          if (state == HDR && cnt == LEN_LSB) begin
            data_len    <= len_new;
            len_clipped <= (len_new > MAX_LIM);
          end
          if (fifo_full && !fifo_pop) overflow <= 1'b1;
        end
      end
    end
  end

  ppm16_sync_fifo #(
    .WIDTH (10),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (fifo_push),
    .din    (fifo_din),
    .pop    (fifo_pop),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule

// File: tb/tb_ppm16_rx_deframer.sv
// Randomized frame-level bench: expected byte streams come from the header
// length rule applied to whole frames, compared against popped output bytes.
module tb_ppm16_rx_deframer;

  localparam int DEPTH = 8;
  localparam int MAXD  = 64;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        packet_detected = 1'b0;
  logic        sym_valid = 1'b0;
  logic [3:0]  sym = '0;
  logic        byte_ready = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_valid, byte_sof, byte_eof, frame_busy, len_clipped, overflow;
  logic [15:0] data_len;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] frame_q[$];
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];

  ppm16_rx_deframer #(
    .HDR_BYTES      (6),
    .LEN_BYTE_IDX   (4),
    .MAX_DATA_BYTES (MAXD),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .packet_detected (packet_detected),
    .sym_valid       (sym_valid),
    .sym             (sym),
    .byte_out        (byte_out),
    .byte_valid      (byte_valid),
    .byte_ready      (byte_ready),
    .byte_sof        (byte_sof),
    .byte_eof        (byte_eof),
    .frame_busy      (frame_busy),
    .data_len        (data_len),
    .len_clipped     (len_clipped),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  // Record every accepted byte; inputs change just after posedge so this sees the handshake.
  always @(negedge clk)
    if (resetn && byte_valid && byte_ready) got_q.push_back({byte_sof, byte_eof, byte_out});

  // Expected data_len for the frame in frame_q: length field + 1, saturating.
  function automatic int model_len();
    int len;
    len = {frame_q[4], frame_q[5]} + 1;
    if (len > 65535) len = 65535;
    return len;
  endfunction

  // Append the bytes a whole frame should produce: 6 header bytes, then min(len,MAXD) data.
  function automatic void model_frame();
    int n;
    n = model_len();
    if (n > MAXD) n = MAXD;
    for (int i = 0; i < 6; i++) exp_q.push_back({(i == 0), 1'b0, frame_q[i]});
    for (int j = 0; j < n; j++) exp_q.push_back({1'b0, (j == n - 1), frame_q[6 + j]});
  endfunction

  // -1 when streams agree, -2 on length mismatch, else first differing index.
  function automatic int first_diff();
    if (got_q.size() != exp_q.size()) return -2;
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  function automatic void make_frame(input int len_field, input int ndata);
    frame_q.delete();
    for (int i = 0; i < 4; i++) frame_q.push_back(8'($urandom));
    frame_q.push_back(8'(len_field >> 8));
    frame_q.push_back(8'(len_field));
    for (int i = 0; i < ndata; i++) frame_q.push_back(8'($urandom));
  endfunction

  // rmode: 0 ready high, 1 ready low, 2 random (never low twice), 3 high from nibble ready_from.
  task automatic drive_frame(input bit gaps, input int rmode, input int ready_from,
                             input int nib_limit, input int rst_at);
    int   total, k;
    bit   prev_low;
    logic [7:0] b;
    total = frame_q.size() * 2;
    if (nib_limit >= 0 && nib_limit < total) total = nib_limit;
    k = 0;
    prev_low = 1'b0;
    @(posedge clk); #1;
    packet_detected = 1'b0;
    sym_valid = 1'b0;
    while (k < total) begin
      @(posedge clk); #1;
      packet_detected = 1'b1;
      case (rmode)
        0: byte_ready = 1'b1;
        1: byte_ready = 1'b0;
        2: begin
             byte_ready = prev_low ? 1'b1 : ($urandom_range(0, 1) == 1);
             prev_low = !byte_ready;
           end
        default: byte_ready = (k >= ready_from);
      endcase
      if (k == rst_at) begin
        sym_valid = 1'b0;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        packet_detected = 1'b0;
        return;
      end
      if (k > 0 && gaps && $urandom_range(0, 2) == 0) begin
        sym_valid = 1'b0;
      end else begin
        b = frame_q[k / 2];
        sym_valid = 1'b1;
        sym = (k % 2 == 0) ? b[7:4] : b[3:0];
        k++;
      end
    end
    @(posedge clk); #1;
    sym_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    byte_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (!byte_valid) break;
    end
    n_checks++;
    if (byte_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain_timeout: byte_valid=%b required 0", name, byte_valid);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (byte_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b req 0", byte_valid); end
    n_checks++; if (frame_busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b req 0", frame_busy); end
    n_checks++; if (data_len !== 16'd0)   begin n_fail++; $display("FAIL reset_len: got %0d req 0", data_len); end
    n_checks++; if ({len_clipped, overflow} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b req 00", {len_clipped, overflow}); end
    n_checks++; if ({byte_sof, byte_eof, byte_out} !== 10'd0) begin n_fail++; $display("FAIL reset_out: got %h req 0", {byte_sof, byte_eof, byte_out}); end
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    int d;
    make_frame(16'h0004, 5);
    frame_q[0] = 8'h00; frame_q[1] = 8'h01; frame_q[2] = 8'h02; frame_q[3] = 8'h03;
    exp_q.delete(); got_q.delete();
    model_frame();
    drive_frame(1'b0, 0, 0, -1, -1);
    drain("basic");
    d = first_diff();
    n_checks++; if (d != -1) begin n_fail++; $display("FAIL basic_seq: got %0d bytes diff@%0d req %0d bytes", got_q.size(), d, exp_q.size()); end
    n_checks++; if (data_len !== 16'd5) begin n_fail++; $display("FAIL basic_len: got %0d req 5", data_len); end
    n_checks++; if ({len_clipped, overflow, frame_busy} !== 3'b000) begin n_fail++; $display("FAIL basic_flags: got %b req 000", {len_clipped, overflow, frame_busy}); end
  endtask

  task automatic test_random();
    int d, len;
    for (int it = 0; it < 5; it++) begin
      len = $urandom_range(0, 20);
      make_frame(len, len + 1 + $urandom_range(0, 2));
      exp_q.delete(); got_q.delete();
      model_frame();
      drive_frame(1'b1, 2, 0, -1, -1);
      drain("random");
      d = first_diff();
      n_checks++; if (d != -1) begin n_fail++; $display("FAIL random_seq[%0d]: got %0d bytes diff@%0d req %0d bytes", it, got_q.size(), d, exp_q.size()); end
      n_checks++; if (data_len !== 16'(model_len())) begin n_fail++; $display("FAIL random_len[%0d]: got %0d req %0d", it, data_len, model_len()); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL random_ovf[%0d]: got %b req 0", it, overflow); end
    end
  endtask

  task automatic test_overflow();
    int d;
    make_frame(16'h0004, 5);
    exp_q.delete(); got_q.delete();
    model_frame();
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    drive_frame(1'b0, 1, 0, -1, -1);
    @(posedge clk); #1;
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b req 1", overflow); end
    n_checks++; if (frame_busy !== 1'b0) begin n_fail++; $display("FAIL ovf_busy: got %b req 0", frame_busy); end
    drain("ovf");
    d = first_diff();
    n_checks++; if (d != -1) begin n_fail++; $display("FAIL ovf_seq: got %0d bytes diff@%0d req %0d bytes", got_q.size(), d, exp_q.size()); end
  endtask

  task automatic test_clip();
    int d;
    make_frame(16'h00FF, 70);
    exp_q.delete(); got_q.delete();
    model_frame();
    drive_frame(1'b0, 0, 0, -1, -1);
    n_checks++; if (frame_busy !== 1'b0) begin n_fail++; $display("FAIL clip_busy: got %b req 0", frame_busy); end
    drain("clip");
    d = first_diff();
    n_checks++; if (d != -1) begin n_fail++; $display("FAIL clip_seq: got %0d bytes diff@%0d req %0d bytes", got_q.size(), d, exp_q.size()); end
    n_checks++; if (data_len !== 16'd256) begin n_fail++; $display("FAIL clip_len: got %0d req 256", data_len); end
    n_checks++; if (len_clipped !== 1'b1) begin n_fail++; $display("FAIL clip_flag: got %b req 1", len_clipped); end
  endtask

  task automatic test_abort();
    int d;
    make_frame(16'h0010, 17);
    exp_q.delete(); got_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back({(i == 0), 1'b0, frame_q[i]});
    drive_frame(1'b0, 1, 0, 7, -1);
    n_checks++; if (frame_busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy: got %b req 1", frame_busy); end
    make_frame(16'h0002, 3);
    model_frame();
    drive_frame(1'b1, 0, 0, -1, -1);
    drain("abort");
    d = first_diff();
    n_checks++; if (d != -1) begin n_fail++; $display("FAIL abort_seq: got %0d bytes diff@%0d req %0d bytes", got_q.size(), d, exp_q.size()); end
    n_checks++; if (data_len !== 16'd3) begin n_fail++; $display("FAIL abort_len: got %0d req 3", data_len); end
  endtask

  task automatic test_full_pop_push();
    int d;
    make_frame(16'h0004, 5);
    exp_q.delete(); got_q.delete();
    model_frame();
    drive_frame(1'b0, 3, 17, -1, -1);
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf: got %b req 0", overflow); end
    drain("fullpop");
    d = first_diff();
    n_checks++; if (d != -1) begin n_fail++; $display("FAIL fullpop_seq: got %0d bytes diff@%0d req %0d bytes", got_q.size(), d, exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    make_frame(16'h0013, 20);
    got_q.delete();
    drive_frame(1'b0, 1, 0, -1, 24);
    n_checks++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b req 0", byte_valid); end
    n_checks++; if (frame_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b req 0", frame_busy); end
    n_checks++; if ({len_clipped, overflow} !== 2'b00) begin n_fail++; $display("FAIL rstmid_flags: got %b req 00", {len_clipped, overflow}); end
    n_checks++; if (data_len !== 16'd0) begin n_fail++; $display("FAIL rstmid_len: got %0d req 0", data_len); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_overflow();
    test_clip();
    test_abort();
    test_full_pop_push();
    test_reset_mid();
    test_basic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
